// File: rtl/switch_pkg.sv
// Shared types and widths for the switch post (output-queue) stage.
package switch_pkg;

  localparam int CELL_W     = 128;
  localparam int CELL_BYTES = 16;
  localparam int PTR_W      = 16;
  localparam int DROP_W     = 16;

  typedef enum logic [1:0] {
    IDLE,
    OPEN,
    ERR
  } wr_state_e;

endpackage

// File: rtl/switch_post_queue.sv
// One output port: frame writer with rollback, cell RAM, byte reader,
// descriptor FIFO, drop counter and backpressure.
module switch_post_queue
  import switch_pkg::*;
#(
  parameter int DATA_DEPTH = 64,
  parameter int PTR_DEPTH  = 16,
  parameter int BP_CELLS   = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              wr_i,
  input  logic              first_i,
  input  logic              last_i,
  input  logic [CELL_W-1:0] din_i,
  input  logic              data_rd_i,
  input  logic              ptr_rd_i,
  output logic              bp_o,
  output logic [7:0]        data_dout_o,
  output logic [PTR_W-1:0]  ptr_dout_o,
  output logic              ptr_empty_o,
  output logic [DROP_W-1:0] drop_cnt_o
);

  localparam int AW  = $clog2(DATA_DEPTH);
  localparam int PAW = $clog2(PTR_DEPTH);

  localparam logic [AW:0]  DEPTH_L = (AW+1)'(DATA_DEPTH);
  localparam logic [AW:0]  BP_L    = (AW+1)'(BP_CELLS);
  localparam logic [AW:0]  ONE_A   = (AW+1)'(1);
  localparam logic [PAW:0] PFULL_L = (PAW+1)'(PTR_DEPTH);
  localparam logic [PAW:0] PHI_L   = (PAW+1)'(PTR_DEPTH-1);
  localparam logic [PAW:0] ONE_P   = (PAW+1)'(1);

  logic [CELL_W-1:0] mem  [DATA_DEPTH];
  logic [PTR_W-1:0]  pmem [PTR_DEPTH];

  wr_state_e state_q, state_d;
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] start_q, start_d;
  logic [AW:0] commit_q, commit_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [3:0]  lane_q, lane_d;
  logic [7:0]  dout_q, dout_d;
  logic [PAW:0] pw_q, pr_q;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic bp_q, bp_d;

  logic [AW:0] used, free, base, cells, mem_wa;
  logic        full, mem_we, push, pop, pfull;
  logic [PAW:0] pcount;
  logic [1:0]  drop_inc;
  logic [DROP_W:0] drop_sum;
  logic [PTR_W-1:0] push_len;
  logic [CELL_W-1:0] rd_word, rd_shift;

  assign used   = wr_ptr_q - rd_ptr_q;
  assign free   = DEPTH_L - used;
  assign full   = (used == DEPTH_L);
  assign pcount = pw_q - pr_q;
  assign pfull  = (pcount == PFULL_L);
  assign pop    = ptr_rd_i && (pcount != '0);

  // A new first rolls an open frame back before restarting at its start.
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    start_d  = start_q;
    commit_d = commit_q;
    drop_inc = 2'd0;
    mem_we   = 1'b0;
    mem_wa   = wr_ptr_q;
    push     = 1'b0;
    push_len = '0;
    base     = wr_ptr_q;
    cells    = '0;
    if (wr_i) begin
      if (first_i) begin
        if (state_q != IDLE) begin
          base     = start_q;
          drop_inc = 2'd1;
        end
        start_d = base;
        if ((base - rd_ptr_q) != DEPTH_L) begin
          mem_we   = 1'b1;
          mem_wa   = base;
          wr_ptr_d = base + ONE_A;
          state_d  = OPEN;
        end else begin
          wr_ptr_d = base;
          state_d  = ERR;
        end
      end else begin
        unique case (state_q)
          OPEN: begin
            if (full) begin
              state_d = ERR;
            end else begin
              mem_we   = 1'b1;
              wr_ptr_d = wr_ptr_q + ONE_A;
            end
          end
          default: ;
        endcase
      end
      if (last_i && state_d != IDLE) begin
        if (state_d == OPEN && !pfull) begin
          commit_d = wr_ptr_d;
          cells    = wr_ptr_d - start_d;
          push     = 1'b1;
          push_len = PTR_W'(cells) << 4;
        end else begin
          wr_ptr_d = start_d;
          drop_inc = drop_inc + 2'd1;
        end
        state_d = IDLE;
      end
    end
  end

  assign drop_sum = {1'b0, drop_q} + {{(DROP_W-1){1'b0}}, drop_inc};
  assign drop_d   = drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];

  assign rd_word  = mem[rd_ptr_q[AW-1:0]];
  assign rd_shift = rd_word << {lane_q, 3'b000};

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    lane_d   = lane_q;
    dout_d   = dout_q;
    if (data_rd_i && rd_ptr_q != commit_q) begin
      dout_d = rd_shift[CELL_W-1 -: 8];
      lane_d = lane_q + 4'd1;
      if (lane_q == 4'hF) rd_ptr_d = rd_ptr_q + ONE_A;
    end
  end

  assign bp_d = (free < BP_L) || (pcount >= PHI_L);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      start_q  <= '0;
      commit_q <= '0;
      rd_ptr_q <= '0;
      lane_q   <= '0;
      dout_q   <= '0;
      pw_q     <= '0;
      pr_q     <= '0;
      drop_q   <= '0;
      bp_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      start_q  <= start_d;
      commit_q <= commit_d;
      rd_ptr_q <= rd_ptr_d;
      lane_q   <= lane_d;
      dout_q   <= dout_d;
      drop_q   <= drop_d;
      bp_q     <= bp_d;
      if (push) pw_q <= pw_q + ONE_P;
      if (pop)  pr_q <= pr_q + ONE_P;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa[AW-1:0]] <= din_i;
    if (push)   pmem[pw_q[PAW-1:0]] <= push_len;
  end

  assign ptr_empty_o = (pcount == '0);
  assign ptr_dout_o  = ptr_empty_o ? '0 : pmem[pr_q[PAW-1:0]];
  assign data_dout_o = dout_q;
  assign drop_cnt_o  = drop_q;
  assign bp_o        = bp_q;

endmodule

// File: rtl/switch_post_mq.sv
// Multi-queue post stage: fans cells out to per-port queues by sel mask
// and flattens the per-port outputs onto shared buses.
module switch_post_mq
  import switch_pkg::*;
#(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_DEPTH = 64,
  parameter int PTR_DEPTH  = 16,
  parameter int BP_CELLS   = 8
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        o_cell_fifo_wr,
  input  logic [NUM_PORTS-1:0]        o_cell_fifo_sel,
  input  logic [CELL_W-1:0]           o_cell_fifo_din,
  input  logic                        o_cell_first,
  input  logic                        o_cell_last,
  output logic [NUM_PORTS-1:0]        o_cell_bp,
  input  logic [NUM_PORTS-1:0]        data_fifo_rd,
  output logic [8*NUM_PORTS-1:0]      data_fifo_dout,
  input  logic [NUM_PORTS-1:0]        ptr_fifo_rd,
  output logic [PTR_W*NUM_PORTS-1:0]  ptr_fifo_dout,
  output logic [NUM_PORTS-1:0]        ptr_fifo_empty,
  output logic [DROP_W*NUM_PORTS-1:0] drop_cnt
);

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_q
    switch_post_queue #(
      .DATA_DEPTH(DATA_DEPTH),
      .PTR_DEPTH (PTR_DEPTH),
      .BP_CELLS  (BP_CELLS)
    ) u_q (
      .clk        (clk),
      .rstn       (rstn),
      .wr_i       (o_cell_fifo_wr & o_cell_fifo_sel[g]),
      .first_i    (o_cell_first),
      .last_i     (o_cell_last),
      .din_i      (o_cell_fifo_din),
      .data_rd_i  (data_fifo_rd[g]),
      .ptr_rd_i   (ptr_fifo_rd[g]),
      .bp_o       (o_cell_bp[g]),
      .data_dout_o(data_fifo_dout[8*g +: 8]),
      .ptr_dout_o (ptr_fifo_dout[PTR_W*g +: PTR_W]),
      .ptr_empty_o(ptr_fifo_empty[g]),
      .drop_cnt_o (drop_cnt[DROP_W*g +: DROP_W])
    );
  end

endmodule

// File: tb/tb_switch_post_mq.sv
// Scoreboard bench for switch_post_mq: expected bytes and descriptors
// are queued per port as frames are sent and checked as they drain.
module tb_switch_post_mq;

  localparam int NP = 4;

  logic          clk = 1'b0;
  logic          rstn;
  logic          wr;
  logic [NP-1:0] sel;
  logic [127:0]  din;
  logic          first, last;
  logic [NP-1:0] bp;
  logic [NP-1:0] drd;
  logic [8*NP-1:0] dout;
  logic [NP-1:0] prd;
  logic [16*NP-1:0] pdout;
  logic [NP-1:0] pempty;
  logic [16*NP-1:0] drop;

  int checks = 0;
  int errors = 0;

  logic [7:0]  exp_data [NP][$];
  logic [15:0] exp_len  [NP][$];

  switch_post_mq #(
    .NUM_PORTS(NP), .DATA_DEPTH(64), .PTR_DEPTH(16), .BP_CELLS(8)
  ) dut (
    .clk(clk), .rstn(rstn),
    .o_cell_fifo_wr(wr), .o_cell_fifo_sel(sel),
    .o_cell_fifo_din(din), .o_cell_first(first), .o_cell_last(last),
    .o_cell_bp(bp),
    .data_fifo_rd(drd), .data_fifo_dout(dout),
    .ptr_fifo_rd(prd), .ptr_fifo_dout(pdout),
    .ptr_fifo_empty(pempty), .drop_cnt(drop)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] mk_cell(input logic [7:0] s);
    logic [127:0] c;
    for (int i = 0; i < 16; i++) c[127-8*i -: 8] = s + 8'(i);
    return c;
  endfunction

  task automatic send_cell(input logic [NP-1:0] m, input logic [7:0] s,
                           input logic f, input logic l);
    wr = 1'b1; sel = m; din = mk_cell(s); first = f; last = l;
    tick();
    wr = 1'b0; sel = '0; first = 1'b0; last = 1'b0;
  endtask

  task automatic send_frame(input logic [NP-1:0] m, input int n,
                            input logic [7:0] s, input bit commit);
    if (commit)
      for (int p = 0; p < NP; p++)
        if (m[p]) begin
          for (int k = 0; k < 16*n; k++) exp_data[p].push_back(s + 8'(k));
          exp_len[p].push_back(16'(16*n));
        end
    for (int c = 0; c < n; c++)
      send_cell(m, s + 8'(16*c), c == 0, c == n-1);
  endtask

  task automatic read_bytes(input int p, input int n);
    logic [7:0] got, e;
    for (int i = 0; i < n; i++) begin
      drd[p] = 1'b1;
      tick();
      got = dout[8*p +: 8];
      checks++;
      if (exp_data[p].size() == 0) begin
        errors++;
        $display("FAIL byte_underflow p%0d: got %02h required none", p, got);
      end else begin
        e = exp_data[p].pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL byte p%0d #%0d: got %02h required %02h", p, i, got, e);
        end
      end
    end
    drd[p] = 1'b0;
  endtask

  task automatic pop_desc(input int p);
    logic [15:0] e;
    checks++;
    if (pempty[p] !== 1'b0) begin
      errors++;
      $display("FAIL desc_present p%0d: got empty=%b required 0", p, pempty[p]);
    end
    e = exp_len[p].pop_front();
    checks++;
    if (pdout[16*p +: 16] !== e) begin
      errors++;
      $display("FAIL desc_len p%0d: got %0d required %0d", p, pdout[16*p +: 16], e);
    end
    prd[p] = 1'b1;
    tick();
    prd[p] = 1'b0;
  endtask

  task automatic drain(input int p);
    int len;
    while (exp_len[p].size() > 0) begin
      len = int'(exp_len[p][0]);
      pop_desc(p);
      read_bytes(p, len);
    end
    checks++;
    if (pempty[p] !== 1'b1 || exp_data[p].size() != 0) begin
      errors++;
      $display("FAIL drained p%0d: got empty=%b left=%0d required 1/0",
               p, pempty[p], exp_data[p].size());
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (bp !== '0 || dout !== '0 || pdout !== '0 ||
        pempty !== '1 || drop !== '0) begin
      errors++;
      $display("FAIL %s: got bp=%h dout=%h pdout=%h empty=%h drop=%h required 0/0/0/f/0",
               tag, bp, dout, pdout, pempty, drop);
    end
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    tick();
    tick();
    check_reset_outputs("reset_state");
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_unicast;
    send_frame(4'b0010, 3, 8'h00, 1'b1);
    checks++;
    if (pempty !== 4'b1101) begin
      errors++;
      $display("FAIL unicast_empty: got %b required 1101", pempty);
    end
    drain(1);
  endtask

  task automatic test_multicast;
    send_frame(4'b1011, 1, 8'h80, 1'b1);
    checks++;
    if (pempty !== 4'b0100) begin
      errors++;
      $display("FAIL mcast_empty: got %b required 0100", pempty);
    end
    drain(0);
    drain(1);
    drain(3);
    checks++;
    if (pempty !== 4'b1111) begin
      errors++;
      $display("FAIL mcast_port2: got %b required 1111", pempty);
    end
  endtask

  task automatic test_overflow;
    for (int f = 0; f < 4; f++) send_frame(4'b0001, 15, 8'(f*40), 1'b1);
    send_frame(4'b0001, 6, 8'hC0, 1'b0);
    checks++;
    if (drop[15:0] !== 16'd1) begin
      errors++;
      $display("FAIL ovf_drop: got %0d required 1", drop[15:0]);
    end
    drain(0);
    tick();
    checks++;
    if (bp[0] !== 1'b0) begin
      errors++;
      $display("FAIL ovf_bp_clear: got %b required 0", bp[0]);
    end
    send_frame(4'b0001, 64, 8'h33, 1'b1);
    checks++;
    if (drop[15:0] !== 16'd1) begin
      errors++;
      $display("FAIL ovf_full_fit: got drop %0d required 1", drop[15:0]);
    end
    drain(0);
  endtask

  task automatic test_missing_last;
    send_cell(4'b0100, 8'hA0, 1'b1, 1'b0);
    send_cell(4'b0100, 8'hB0, 1'b0, 1'b0);
    send_frame(4'b0100, 1, 8'hC0, 1'b1);
    checks++;
    if (drop[47:32] !== 16'd1) begin
      errors++;
      $display("FAIL noLast_drop: got %0d required 1", drop[47:32]);
    end
    drain(2);
  endtask

  task automatic test_backpressure;
    send_frame(4'b1000, 56, 8'h01, 1'b1);
    tick();
    tick();
    checks++;
    if (bp[3] !== 1'b0) begin
      errors++;
      $display("FAIL bp_free8: got %b required 0", bp[3]);
    end
    send_frame(4'b1000, 1, 8'h77, 1'b1);
    checks++;
    if (bp[3] !== 1'b0) begin
      errors++;
      $display("FAIL bp_latency: got %b required 0", bp[3]);
    end
    tick();
    checks++;
    if (bp[3] !== 1'b1) begin
      errors++;
      $display("FAIL bp_assert: got %b required 1", bp[3]);
    end
    read_bytes(3, 16);
    checks++;
    if (bp[3] !== 1'b1) begin
      errors++;
      $display("FAIL bp_hold: got %b required 1", bp[3]);
    end
    tick();
    checks++;
    if (bp[3] !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: got %b required 0", bp[3]);
    end
    pop_desc(3);
    read_bytes(3, 880);
    drain(3);
  endtask

  task automatic test_reset_mid;
    send_cell(4'b0001, 8'h50, 1'b1, 1'b0);
    rstn = 1'b0;
    send_cell(4'b0001, 8'h60, 1'b0, 1'b0);
    rstn = 1'b1;
    check_reset_outputs("midreset_state");
    send_cell(4'b0001, 8'h70, 1'b0, 1'b0);
    send_cell(4'b0001, 8'h80, 1'b0, 1'b1);
    checks++;
    if (drop !== '0 || pempty !== 4'hF) begin
      errors++;
      $display("FAIL midreset_tail: got drop=%h empty=%b required 0/1111", drop, pempty);
    end
    send_frame(4'b0001, 2, 8'hE0, 1'b1);
    drain(0);
  endtask

  initial begin
    rstn = 1'b0; wr = 1'b0; sel = '0; din = '0;
    first = 1'b0; last = 1'b0; drd = '0; prd = '0;
    test_reset();
    test_unicast();
    test_multicast();
    test_overflow();
    test_missing_last();
    test_backpressure();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/switch_post_mq.md
Name: switch_post_mq

Overview:
Parametrised output-queue stage of the switch datapath. Accepts 128-bit cells from the switch core, buffers them in NUM_PORTS independent per-port queues, and presents each queue as a byte-wide data FIFO plus a frame-descriptor pointer FIFO to the port transmitters. It replaces the fixed 4-port post stage and adds:
- multicast: several sel bits set writes the cell to each selected queue.
- per-port frame rollback on overflow, with drop counters.
- programmable backpressure threshold.

Parameters:
NUM_PORTS, 4, number of output queues (1..16)
DATA_DEPTH, 64, data FIFO depth per port in 16-byte cells (power of 2)
PTR_DEPTH, 16, pointer FIFO depth per port in frames (power of 2)
BP_CELLS, 8, o_cell_bp asserts when free cells < BP_CELLS (must be <= DATA_DEPTH)

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset
o_cell_fifo_wr  in  1  cell valid this cycle
o_cell_fifo_sel  in  NUM_PORTS  destination mask (one or more bits)
o_cell_fifo_din  in  128  cell payload, byte 0 = [127:120]
o_cell_first  in  1  first cell of frame
o_cell_last  in  1  last cell of frame (first and last may both be set)
o_cell_bp  out  NUM_PORTS  per-port backpressure to core
data_fifo_rd  in  NUM_PORTS  per-port byte read strobe
data_fifo_dout  out  8*NUM_PORTS  per-port byte, port p at [8p+7:8p]
ptr_fifo_rd  in  NUM_PORTS  per-port descriptor pop
ptr_fifo_dout  out  16*NUM_PORTS  descriptor: frame length in bytes = cells*16
ptr_fifo_empty  out  NUM_PORTS  descriptor FIFO empty
drop_cnt  out  16*NUM_PORTS  per-port dropped-frame count, saturating

Behaviour:
- Reset (rstn=0 at posedge):
  - All pointers, counters and frame state cleared.
  - o_cell_bp=0, data_fifo_dout=0, ptr_fifo_dout=0, ptr_fifo_empty=all 1, drop_cnt=0.
  - Reset mid-frame discards the partial frame without counting a drop.
- Per-port writer state: IDLE / OPEN / ERR. Holds frame_start (cell address), wr_ptr (uncommitted) and commit_ptr.
- On wr with sel[p]=1:
  - IDLE, first=1: frame_start:=wr_ptr. If space, store the cell, wr_ptr+1, go OPEN; else go ERR.
  - IDLE, first=0: cell discarded silently, no count.
  - OPEN/ERR, first=1: the previous frame is rolled back (wr_ptr:=frame_start) and drop_cnt+1. The new frame then starts as in IDLE.
  - OPEN, data FIFO full (wr_ptr-rd_cell_ptr==DATA_DEPTH): cell discarded, go ERR.
  - ERR: cells discarded.
- On last=1 (same cycle as the write):
  - OPEN with ptr FIFO not full: commit_ptr:=wr_ptr(after write), push length=(cells in frame)*16, go IDLE.
  - Otherwise: rollback wr_ptr:=frame_start, drop_cnt+1, go IDLE.
  - drop_cnt saturates at 0xFFFF.
- Reader:
  - Byte lane counter 0..15 selects bytes 0..15 of the cell at rd_cell_ptr.
  - data_fifo_rd[p] with committed data available (rd_cell_ptr!=commit_ptr): data_fifo_dout updates on the next edge (1-cycle registered latency). Lane 15 advances rd_cell_ptr.
  - Read with no committed data is ignored; dout holds.
  - The reader never sees uncommitted or rolled-back cells.
- Pointer FIFO:
  - ptr_fifo_dout is first-word-fall-through: valid whenever ptr_fifo_empty=0.
  - ptr_fifo_rd pops; a pop while empty is ignored.
  - A push and a pop in the same cycle are both honoured.
  - A push becomes visible (empty deasserts) the cycle after the commit edge.
- Pointer arithmetic: pointers are log2(DATA_DEPTH)+1 bits and wrap naturally. Free = DATA_DEPTH-(wr_ptr-rd_cell_ptr).
- Backpressure: o_cell_bp[p] registered, 1-cycle latency. Asserted when free < BP_CELLS OR ptr FIFO count >= PTR_DEPTH-1. Held while the condition holds.
- Write and read on the same port in one cycle are both honoured. Full/free is computed from pre-edge values, so no bypass.

Decomposition:
- Package switch_pkg: CELL_W=128, CELL_BYTES=16, PTR_W=16, DROP_W=16, writer state enum {IDLE, OPEN, ERR}.
- Sub-module switch_post_queue: one port's writer FSM, cell RAM, byte reader, pointer FIFO and drop counter.
- Top instantiates NUM_PORTS copies in a generate loop and does only sel fan-out and bus flattening.

Test Plan:
1. Unicast: 3-cell frame, sel=4'b0010, bytes 0x00..0x2F. Then ptr_fifo_empty1 falls, ptr_fifo_dout1=48, and 48 reads return 0x00..0x2F in order. Other ports stay empty.
2. Multicast: 1-cell frame (first=last=1), sel=4'b1011. Ports 0, 1 and 3 each show descriptor 16 and identical 16 bytes. Port 2 stays empty.
3. Overflow rollback: DATA_DEPTH=64. Fill port 0 with 4 committed 15-cell frames (4 cells free), then send a 6-cell frame. drop_cnt0=1, only 4 descriptors present, and after draining free returns to 64.
4. Missing last: first, 2 cells, then first again with a 1-cell last frame. drop_cnt=1, a single descriptor of 16, and the payload is the second frame's.
5. Backpressure: BP_CELLS=8. Fill to 57 used cells: o_cell_bp asserts 1 cycle after the write that makes free=7. It deasserts 1 cycle after reads bring free back to 8.
6. Reset mid-frame: rstn low for 1 cycle during cell 2 of a 4-cell frame. All outputs return to reset values, drop_cnt=0, and the next clean frame is delivered intact.
